uart_tx_queue: RTL
==================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter START_WAIT, default 8, max cycles to wait for uio_busy to rise after a command write.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_addr  in  4  CPU register select.
REQ-006 SHALL have port cpu_wdata  in  32  CPU write data.
REQ-007 SHALL have port cpu_rdata  out  32  CPU read data, registered.
REQ-008 SHALL have port cpu_en  in  1  CPU access strobe.
REQ-009 SHALL have port cpu_wen  in  1  1=write, 0=read when cpu_en=1.
REQ-010 SHALL have port uio_addr  out  4  register select to downstream UART_IO.
REQ-011 SHALL have port uio_data  out  32  write data to UART_IO.
REQ-012 SHALL have port uio_en  out  1  UART_IO access strobe.
REQ-013 SHALL have port uio_wen  out  1  UART_IO write select.
REQ-014 SHALL have port uio_busy  in  1  UART_IO busy flag.
REQ-015 SHALL have port irq_empty  out  1  high when FIFO empty and FSM in IDLE.

Function
REQ-016 CPU map: addr 0 write = push cpu_wdata[7:0]; addr 1 read = STATUS {19'b0, tx_err, ovf, count[8:0] zero-extended to DEPTH, full, empty} with count in [10:2]; addr 2 write = CTRL (bit0 flush, bit1 clear ovf and tx_err); other addresses: writes ignored, reads return 0.
REQ-017 CPU reads SHALL update cpu_rdata one cycle after cpu_en=1,cpu_wen=0; cpu_rdata holds otherwise.
REQ-018 Push accepted when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle; rejected push drops byte and sets sticky ovf.
REQ-019 count SHALL be unchanged on simultaneous push+pop; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 FSM states IDLE, WR_DATA, WR_CMD, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> WR_DATA when count>0 and uio_busy=0; else stay.
REQ-022 WR_DATA (one cycle): uio_addr=1, uio_data={24'b0,head byte}, uio_en=1, uio_wen=1; FIFO pops this cycle; -> WR_CMD.
REQ-023 WR_CMD (one cycle): uio_addr=0, uio_data=32'h1, uio_en=1, uio_wen=1; -> WAIT_BUSY, wait counter cleared.
REQ-024 WAIT_BUSY: uio_en=0; uio_busy=1 -> WAIT_DONE; counter reaching START_WAIT without busy -> set sticky tx_err, -> IDLE (byte lost).
REQ-025 WAIT_DONE: uio_en=0; uio_busy=0 -> IDLE.
REQ-026 uio_en SHALL be 1 only in WR_DATA/WR_CMD; uio_addr, uio_data, uio_wen SHALL be 0 in all other states.
REQ-027 Flush clears pointers and count in that cycle; an already-popped byte in flight completes normally; a push in the same cycle as flush is discarded.
REQ-028 Clear-sticky and a new ovf event in the same cycle: ovf SHALL end set.
REQ-029 Byte order on the UART SHALL equal push order; no byte is sent twice.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM IDLE, pointers/count 0, ovf=0, tx_err=0, cpu_rdata=0, uio_addr=0, uio_data=0, uio_en=0, uio_wen=0, irq_empty=1.
REQ-031 Reset mid-transfer abandons the FIFO contents; after release the block waits for uio_busy=0 before its next WR_DATA.

Verification
REQ-032 Push 0x41,0x42,0x43 with UART_IO model -> three WR_DATA/WR_CMD pairs, bytes 0x41,0x42,0x43 in order, irq_empty=1 after last busy fall.
REQ-033 Push 17 bytes with uio_busy held 1 -> count=16, full=1, ovf=1, 17th byte never sent.
REQ-034 With count=16, push+pop same cycle -> push accepted, count stays 16, ovf stays 0.
REQ-035 uio_busy never rises after WR_CMD -> IDLE after 8 cycles, tx_err=1; CTRL write 0x2 -> tx_err=0, ovf=0.
REQ-036 Flush during WAIT_DONE with 5 queued -> in-flight byte completes, count=0, no further uio_en.
REQ-037 rst_n low during WR_CMD -> uio_en=0 asynchronously, STATUS read after release = 0x1 (empty only).

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of a register-mapped UART_IO block: the CPU pushes bytes,
// the sender FSM writes each byte and then a start command downstream.
module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int START_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        cpu_en,
  input  logic        cpu_wen,
  output logic [3:0]  uio_addr,
  output logic [31:0] uio_data,
  output logic        uio_en,
  output logic        uio_wen,
  input  logic        uio_busy,
  output logic        irq_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state, state_next;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [15:0]    wait_cnt, wait_next;
  logic           ovf, tx_err, err_evt;

  logic cpu_wr, push, ctrl_wr, flush, clr, pop, full, empty, push_ok, ovf_evt;
  logic [8:0] count9;

  assign cpu_wr  = cpu_en & cpu_wen;
  assign push    = cpu_wr & (cpu_addr == 4'd0);
  assign ctrl_wr = cpu_wr & (cpu_addr == 4'd2);
  assign flush   = ctrl_wr & cpu_wdata[0];
  assign clr     = ctrl_wr & cpu_wdata[1];
  assign pop     = (state == WR_DATA);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push & ~flush & (~full | pop);
  assign ovf_evt = push & ~flush & full & ~pop;
  assign count9  = 9'(count);
  assign irq_empty = empty & (state == IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= cpu_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      tx_err    <= 1'b0;
      cpu_rdata <= '0;
      state     <= IDLE;
      wait_cnt  <= '0;
    end else begin
      // Clearing never hides an event that lands in the same cycle.
      ovf      <= (ovf & ~clr) | ovf_evt;
      tx_err   <= (tx_err & ~clr) | err_evt;
      state    <= state_next;
      wait_cnt <= wait_next;
      if (cpu_en && !cpu_wen)
        cpu_rdata <= (cpu_addr == 4'd1) ? {19'b0, tx_err, ovf, count9, full, empty} : 32'd0;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    err_evt    = 1'b0;
    uio_addr   = 4'd0;
    uio_data   = 32'd0;
    uio_en     = 1'b0;
    uio_wen    = 1'b0;
    case (state)
      IDLE: begin
        // A flush in this cycle empties the FIFO, so do not start on stale count.
        if (!empty && !uio_busy && !flush) state_next = WR_DATA;
      end
      WR_DATA: begin
        uio_addr   = 4'd1;
        uio_data   = {24'b0, mem[rd_ptr]};
        uio_en     = 1'b1;
        uio_wen    = 1'b1;
        state_next = WR_CMD;
      end
      WR_CMD: begin
        uio_addr   = 4'd0;
        uio_data   = 32'h1;
        uio_en     = 1'b1;
        uio_wen    = 1'b1;
        wait_next  = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uio_busy) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt >= 16'(START_WAIT - 1)) begin
          err_evt    = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_cnt + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!uio_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
